// File: rtl/vlsu_cam_pkg.sv
// Shared defaults and entry/key types for the vector load/store unit CAM.
package vlsu_cam_pkg;

  localparam int DEF_WIDTH   = 50;
  localparam int DEF_DEPTH   = 32;
  localparam int DEF_WRITE   = 1;
  localparam int DEF_READ    = 3;
  localparam int DEF_ADDRESS = $clog2(DEF_DEPTH);

  typedef logic [DEF_WIDTH-1:0]   width_t;
  typedef logic [DEF_ADDRESS-1:0] addr_t;
  typedef logic [DEF_DEPTH-1:0]   depth_t;
  typedef logic [DEF_WRITE-1:0]   write_t;
  typedef logic [DEF_READ-1:0]    read_t;

endpackage

// File: rtl/vlsu_cam_prio_enc.sv
// Rotating-start priority encoder: first set bit scanning upward from head_i, wrapping at DEPTH.
module vlsu_cam_prio_enc
  import vlsu_cam_pkg::*;
#(
  parameter  int DEPTH   = DEF_DEPTH,
  localparam int ADDRESS = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]   hit_i,
  input  logic [ADDRESS-1:0] head_i,
  output logic               found_o,
  output logic [ADDRESS-1:0] index_o
);

  // Scan from the far end back toward head so the entry closest to head is written last.
  always_comb begin
    logic [ADDRESS-1:0] pos;
    pos     = '0;
    found_o = 1'b0;
    index_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      pos = head_i + ADDRESS'(i);
      if (hit_i[pos]) begin
        found_o = 1'b1;
        index_o = pos;
      end
    end
  end

endmodule

// File: rtl/vlsu_cam_top.sv
// Multi-port CAM tracking VLSU addresses/IDs: WRITE write ports, READ registered search ports.
module vlsu_cam_top
  import vlsu_cam_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int DEPTH   = DEF_DEPTH,
  parameter  int WRITE   = DEF_WRITE,
  parameter  int READ    = DEF_READ,
  localparam int ADDRESS = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic [ADDRESS-1:0]             head_i,
  input  logic [READ-1:0][DEPTH-1:0]     enable_i,
  input  logic [WRITE-1:0]               write_i,
  input  logic [WRITE-1:0][ADDRESS-1:0]  write_addr_i,
  input  logic [WRITE-1:0][WIDTH-1:0]    write_data_i,
  input  logic [READ-1:0]                read_i,
  input  logic [READ-1:0][WIDTH-1:0]     read_data_i,
  output logic [READ-1:0]                match_o,
  output logic [READ-1:0][ADDRESS-1:0]   match_data_o
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0]            valid_q;
  logic [READ-1:0][DEPTH-1:0]  hit;
  logic [READ-1:0]             found;
  logic [READ-1:0][ADDRESS-1:0] index;

  // Later write ports overwrite earlier ones on an address collision.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      for (int w = 0; w < WRITE; w++) begin
        if (write_i[w]) begin
          data_q[write_addr_i[w]]  <= write_data_i[w];
          valid_q[write_addr_i[w]] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int r = 0; r < READ; r++) begin
      for (int e = 0; e < DEPTH; e++) begin
        hit[r][e] = valid_q[e] && enable_i[r][e] && (data_q[e] == read_data_i[r]);
      end
    end
  end

  for (genvar r = 0; r < READ; r++) begin : g_enc
    vlsu_cam_prio_enc #(
      .DEPTH (DEPTH)
    ) u_enc (
      .hit_i   (hit[r]),
      .head_i  (head_i),
      .found_o (found[r]),
      .index_o (index[r])
    );
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      match_o      <= '0;
      match_data_o <= '0;
    end else begin
      for (int r = 0; r < READ; r++) begin
        match_o[r]      <= read_i[r] && found[r];
        match_data_o[r] <= (read_i[r] && found[r]) ? index[r] : '0;
      end
    end
  end

endmodule

// File: tb/tb_vlsu_cam_top.sv
// Scoreboard bench for vlsu_cam_top: default instance plus a WRITE=2 instance for port conflicts.
module tb_vlsu_cam_top;
  import vlsu_cam_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int D = DEF_DEPTH;
  localparam int R = DEF_READ;
  localparam int A = DEF_ADDRESS;

  typedef logic [D-1:0][W-1:0] mem_t;

  typedef struct {
    logic [R-1:0]        m;
    logic [R-1:0][A-1:0] idx;
    logic [R-1:0]        m2;
    logic [R-1:0][A-1:0] idx2;
  } exp_t;

  logic                clk = 1'b0;
  logic                arst_n;
  addr_t               head;
  logic [R-1:0][D-1:0] enable;
  logic [0:0]          wr;
  logic [0:0][A-1:0]   waddr;
  logic [0:0][W-1:0]   wdata;
  logic [R-1:0]        rd;
  logic [R-1:0][W-1:0] rdata;
  logic [R-1:0]        match;
  logic [R-1:0][A-1:0] match_data;

  logic [1:0]          wr2;
  logic [1:0][A-1:0]   waddr2;
  logic [1:0][W-1:0]   wdata2;
  logic [R-1:0]        rd2;
  logic [R-1:0][W-1:0] rdata2;
  logic [R-1:0][D-1:0] enable2;
  logic [R-1:0]        match2;
  logic [R-1:0][A-1:0] match_data2;

  mem_t   mdata, mdata2;
  depth_t mvalid, mvalid2;
  exp_t   sb[$];
  int     checks = 0;
  int     failures = 0;
  int     step = 0;

  always #5 clk = ~clk;

  vlsu_cam_top dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .head_i       (head),
    .enable_i     (enable),
    .write_i      (wr),
    .write_addr_i (waddr),
    .write_data_i (wdata),
    .read_i       (rd),
    .read_data_i  (rdata),
    .match_o      (match),
    .match_data_o (match_data)
  );

  vlsu_cam_top #(.WRITE(2)) dut2 (
    .clk          (clk),
    .arst_n       (arst_n),
    .head_i       (head),
    .enable_i     (enable2),
    .write_i      (wr2),
    .write_addr_i (waddr2),
    .write_data_i (wdata2),
    .read_i       (rd2),
    .read_data_i  (rdata2),
    .match_o      (match2),
    .match_data_o (match_data2)
  );

  function automatic void modelSearch(input mem_t d, input depth_t v, input width_t key,
                                      input depth_t en, input addr_t hd, input logic rdv,
                                      output logic m, output addr_t ix);
    int e;
    m  = 1'b0;
    ix = '0;
    if (rdv) begin
      for (int k = 0; k < D; k++) begin
        e = (int'(hd) + k) % D;
        if (!m && v[e] && en[e] && d[e] == key) begin
          m  = 1'b1;
          ix = addr_t'(e);
        end
      end
    end
  endfunction

  task automatic checkOutput();
    exp_t it;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_empty step%0d observed=0 expected=1", step);
    end
    if (sb.size() != 0) begin
      it = sb.pop_front();
      for (int r = 0; r < R; r++) begin
        checks++;
        assert (match[r] === it.m[r]) else begin
          failures++;
          $error("[TB] FAIL match_p%0d step%0d observed=%b expected=%b", r, step, match[r], it.m[r]);
        end
        checks++;
        assert (match_data[r] === it.idx[r]) else begin
          failures++;
          $error("[TB] FAIL index_p%0d step%0d observed=%0d expected=%0d", r, step, match_data[r], it.idx[r]);
        end
        checks++;
        assert (match2[r] === it.m2[r]) else begin
          failures++;
          $error("[TB] FAIL w2_match_p%0d step%0d observed=%b expected=%b", r, step, match2[r], it.m2[r]);
        end
        checks++;
        assert (match_data2[r] === it.idx2[r]) else begin
          failures++;
          $error("[TB] FAIL w2_index_p%0d step%0d observed=%0d expected=%0d", r, step, match_data2[r], it.idx2[r]);
        end
      end
    end
  endtask

  // Expected results use model state from before this edge; writes land in the model afterwards.
  task automatic applyStimulus();
    exp_t it;
    for (int r = 0; r < R; r++) begin
      if (!arst_n) begin
        it.m[r] = 1'b0;  it.idx[r] = '0;
        it.m2[r] = 1'b0; it.idx2[r] = '0;
      end else begin
        modelSearch(mdata, mvalid, rdata[r], enable[r], head, rd[r], it.m[r], it.idx[r]);
        modelSearch(mdata2, mvalid2, rdata2[r], enable2[r], head, rd2[r], it.m2[r], it.idx2[r]);
      end
    end
    sb.push_back(it);
    if (!arst_n) begin
      mdata = '0; mvalid = '0; mdata2 = '0; mvalid2 = '0;
    end else begin
      if (wr[0]) begin
        mdata[waddr[0]] = wdata[0];
        mvalid[waddr[0]] = 1'b1;
      end
      for (int w = 0; w < 2; w++) begin
        if (wr2[w]) begin
          mdata2[waddr2[w]] = wdata2[w];
          mvalid2[waddr2[w]] = 1'b1;
        end
      end
    end
    @(negedge clk);
    step++;
    checkOutput();
  endtask

  task automatic idle();
    wr = '0; rd = '0; wr2 = '0; rd2 = '0;
    waddr = '0; wdata = '0; rdata = '0; waddr2 = '0; wdata2 = '0; rdata2 = '0;
    head = '0;
    enable = '1;
    enable2 = '1;
  endtask

  task automatic searchAll(input width_t key);
    rd = '1;
    for (int r = 0; r < R; r++) rdata[r] = key;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired step%0d", step);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    mdata = '0; mvalid = '0; mdata2 = '0; mvalid2 = '0;
    idle();
    arst_n = 1'b0;
    applyStimulus();
    applyStimulus();
    arst_n = 1'b1;

    // Key 0 against an empty CAM must miss on every port.
    searchAll('0);
    applyStimulus();

    // Write row, and on the same cycle search the value written one cycle earlier.
    for (int row = 0; row <= D; row++) begin
      idle();
      if (row < D) begin
        wr[0] = 1'b1; waddr[0] = A'(row); wdata[0] = W'(row + 1);
      end
      if (row > 0) searchAll(W'(row));
      applyStimulus();
    end

    for (int row = 0; row <= D; row++) begin
      idle();
      if (row < D) begin
        wr[0] = 1'b1; waddr[0] = A'(row); wdata[0] = W'(33 - row);
      end
      if (row > 0) searchAll(W'(33 - (row - 1)));
      applyStimulus();
    end

    // Reset with a search in flight wipes everything.
    idle();
    searchAll(W'(20));
    arst_n = 1'b0;
    applyStimulus();
    arst_n = 1'b1;
    idle();
    searchAll(W'(20));
    applyStimulus();

    idle();
    wr[0] = 1'b1; waddr[0] = A'(4); wdata[0] = W'(5);
    applyStimulus();
    idle();
    rd = '1;
    rdata[0] = W'(5); enable[0][4] = 1'b0;
    rdata[1] = W'(5);
    rdata[2] = W'(99);
    applyStimulus();

    idle();
    wr[0] = 1'b1; waddr[0] = A'(3); wdata[0] = W'(7);
    applyStimulus();
    idle();
    wr[0] = 1'b1; waddr[0] = A'(20); wdata[0] = W'(7);
    applyStimulus();
    idle(); searchAll(W'(7)); head = A'(0);
    applyStimulus();
    idle(); searchAll(W'(7)); head = A'(10);
    applyStimulus();
    idle(); searchAll(W'(7)); head = A'(25);
    applyStimulus();

    // Same-edge write and search: the search must see the old contents.
    idle();
    wr[0] = 1'b1; waddr[0] = A'(2); wdata[0] = W'(9);
    searchAll(W'(9));
    applyStimulus();
    idle(); searchAll(W'(9));
    applyStimulus();

    idle();
    wr2 = 2'b11;
    waddr2[0] = A'(6); wdata2[0] = W'(111);
    waddr2[1] = A'(6); wdata2[1] = W'(222);
    applyStimulus();
    idle();
    rd2 = '1;
    rdata2[0] = W'(222);
    rdata2[1] = W'(111);
    rdata2[2] = W'(222);
    applyStimulus();

    idle();
    applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vlsu_cam_top.md
Name: vlsu_cam_top

Overview:
- Multi-port content-addressable memory for the vector load/store unit's address/ID tracking.
- Has DEPTH entries of WIDTH bits, WRITE write ports and READ search ports.
- Each search port compares a key against all valid, enabled entries.
- Each search port returns a hit flag plus the index of the selected matching entry.
- Selection uses a rotating priority starting at head_i (queue head).

Parameters:
- WIDTH, 50, bits per entry / search key
- DEPTH, 32, number of entries (power of two, >=2)
- WRITE, 1, number of write ports
- READ, 3, number of search ports
- ADDRESS, $clog2(DEPTH), entry index width (derived, not overridden)

Ports:
- clk  in  1  clock, all state on rising edge
- arst_n  in  1  reset, synchronous, active-low
- head_i  in  ADDRESS  priority start index for match selection
- enable_i  in  READ x DEPTH  per-search-port entry mask; bit e=1 allows entry e to match on that port
- write_i  in  WRITE  per-port write strobe
- write_addr_i  in  WRITE x ADDRESS  write entry index
- write_data_i  in  WRITE x WIDTH  write data
- read_i  in  READ  per-port search strobe
- read_data_i  in  READ x WIDTH  search key
- match_o  out  READ  per-port hit flag
- match_data_o  out  READ x ADDRESS  per-port index of the selected matching entry

Behaviour:
- Storage:
  - DEPTH x WIDTH data registers plus one valid bit per entry.
  - On a rising edge with arst_n=0, all data clear to 0, all valid bits clear to 0, match_o=0 and match_data_o=0.
- Write:
  - At a rising edge with write_i[w]=1, entry write_addr_i[w] takes write_data_i[w] and its valid bit sets.
  - Valid bits are never cleared except by reset.
  - If two write ports hit the same address in one cycle, the highest port index wins.
- Search (per port r, independent):
  - Inputs read_i[r], read_data_i[r], enable_i[r] and head_i are sampled at a rising edge.
  - Entry e hits when valid[e] && enable_i[r][e] && data[e]==read_data_i[r], using the stored state before that edge.
- Latency:
  - Results are registered and appear one cycle after the sampling edge.
  - match_o[r] = read_i[r] && (any hit).
  - match_data_o[r] = index of the first hitting entry scanning head_i, head_i+1, ..., DEPTH-1, 0, ..., head_i-1 (modulo DEPTH).
  - If read_i[r]=0 or no hit: match_o[r]=0 and match_data_o[r]=0.
- Write/search ordering:
  - A write committed at edge N is visible to a search sampled at edge N+1, so its result is visible after edge N+1.
  - There is no same-edge bypass: a search sampled at the same edge as a write sees the old entry.
- Invalid entries never match, including a key of 0 after reset.
- Duplicate stored values are allowed; priority selects one.
- Reset asserted mid-operation discards all contents. The outputs are 0 on the cycle after the reset edge.
- There are no handshakes and no back-pressure; every cycle accepts new writes and searches.

Decomposition:
- Package vlsu_cam_pkg holds:
  - default WIDTH/DEPTH/WRITE/READ constants
  - typedefs width_t, addr_t, depth_t (entry bit-vector), write_t, read_t
- Sub-module vlsu_cam_prio_enc (rotating-start priority encoder):
  - Inputs: DEPTH-bit hit vector and head index.
  - Outputs: found flag and ADDRESS-bit index.
  - Instantiated READ times.

Test Plan:
- Reset state: after reset, search key 0 on all 3 ports with all enables=1 -> match_o=3'b000, match_data_o=0.
- Write-then-search back-to-back (DEPTH=32):
  - For rows 0..31, write addr=row, data=row+1 in cycle N.
  - In cycle N+1, all 3 ports search row+1.
  - Required: one cycle later match_o=3'b111 and match_data_o=row on every port.
- Overwrite: repeat the sweep with data=33-row at addr=row, searching 33-row the next cycle -> match_o=3'b111, match_data_o=row. The old value (row+1) is no longer at that entry.
- Enable mask / miss:
  - Write 5 to entry 4.
  - Port 0 searches 5 with enable bit 4 cleared -> match_o[0]=0.
  - Port 1 searches 5 with enable bit 4 set -> match_o[1]=1, match_data_o[1]=4.
  - Port 2 searches 99 -> match_o[2]=0.
- Rotating priority:
  - Write 7 to entries 3 and 20.
  - head_i=0 -> match_data_o=3.
  - head_i=10 -> 20.
  - head_i=25 -> 3 (wrap).
- Same-edge write/search and port conflict:
  - Search 9 at the same edge as writing 9 to entry 2 -> no match.
  - The next-cycle search -> match, index 2.
  - With WRITE=2, both ports writing entry 6 -> the port-1 data is stored.
